// File: rtl/core_pkg.sv
// Shared fetch-side types and constants for the RV32I front end.
package core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // Front-end action for the current cycle; HOLD outranks REDIRECT.
  typedef enum logic [1:0] {
    ACT_RUN,
    ACT_HOLD,
    ACT_REDIRECT
  } fe_action_t;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/pipeline_frontend_if.sv
// Hazard-unit / instruction-memory side bus of the fetch front end.
// master drives the hazard decisions and fetch data; slave is the front end.
interface pipeline_frontend_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);

  logic                  Stall;
  logic                  Flush;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic [DATA_WIDTH-1:0] InstrF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [DATA_WIDTH-1:0] PCD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic                  ValidD;
  logic                  FlushE;
  logic [CNT_WIDTH-1:0]  StallCnt;
  logic [CNT_WIDTH-1:0]  FlushCnt;

  modport master (
    output Stall, Flush, PCTargetE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, FlushE, StallCnt, FlushCnt
  );

  modport slave (
    input  Stall, Flush, PCTargetE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, FlushE, StallCnt, FlushCnt
  );

endinterface

// File: rtl/pipeline_frontend_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled cycles until the counter is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_frontend.sv
// Fetch-side controller: owns PC and IF/ID, turns Stall/Flush into
// hold/redirect/squash actions and requests the ID/EX bubble.
// The IF/ID record uses core_pkg::if_id_t, so DATA_WIDTH is expected to be XLEN.
module pipeline_frontend #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = core_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = core_pkg::NOP_INSTR,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_frontend_if.slave   bus
);

  import core_pkg::*;

  fe_action_t            w_action;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic                  w_stall_en;
  logic                  w_flush_en;
  logic [DATA_WIDTH-1:0] r_pcf;
  if_id_t                r_if_id;

  // Stall wins over Flush: a stalled E-stage branch has stale operands.
  always_comb begin
    w_action = ACT_RUN;
    if (bus.Stall) begin
      w_action = ACT_HOLD;
    end else if (bus.Flush) begin
      w_action = ACT_REDIRECT;
    end
  end

  assign w_pc_plus4 = r_pcf + DATA_WIDTH'(4);
  assign w_stall_en = (w_action == ACT_HOLD);
  assign w_flush_en = (w_action == ACT_REDIRECT);

  // PC and IF/ID update; reset discards whatever action was pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcf            <= RESET_PC;
      r_if_id.instr    <= NOP_INSTR;
      r_if_id.pc       <= '0;
      r_if_id.pc_plus4 <= '0;
      r_if_id.valid    <= 1'b0;
    end else begin
      case (w_action)
        ACT_HOLD: begin
          r_pcf   <= r_pcf;
          r_if_id <= r_if_id;
        end
        ACT_REDIRECT: begin
          r_pcf            <= bus.PCTargetE;
          r_if_id.instr    <= NOP_INSTR;
          r_if_id.pc       <= '0;
          r_if_id.pc_plus4 <= '0;
          r_if_id.valid    <= 1'b0;
        end
        default: begin
          r_pcf            <= w_pc_plus4;
          r_if_id.instr    <= bus.InstrF;
          r_if_id.pc       <= r_pcf;
          r_if_id.pc_plus4 <= w_pc_plus4;
          r_if_id.valid    <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_stall_en),
    .o_count (bus.StallCnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_flush_en),
    .o_count (bus.FlushCnt)
  );

  // Bubble into ID/EX on hold, redirect, and throughout reset.
  assign bus.FlushE   = rst | (w_action != ACT_RUN);
  assign bus.PCF      = r_pcf;
  assign bus.InstrD   = r_if_id.instr;
  assign bus.PCD      = r_if_id.pc;
  assign bus.PCPlus4D = r_if_id.pc_plus4;
  assign bus.ValidD   = r_if_id.valid;

endmodule

// File: tb/tb_pipeline_frontend.sv
module tb_pipeline_frontend;

  logic clk = 1'b0;
  logic s_rst = 1'b1;
  logic s_stall = 1'b0;
  logic s_flush = 1'b0;
  logic [31:0] s_tgt = 32'h0;

  int n_chk = 0;
  int n_fail = 0;

  logic obs_fe_a, obs_fe_b;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_valid;
  longint      m_scnt, m_fcnt;

  always #5 clk = ~clk;

  pipeline_frontend_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus_a ();
  pipeline_frontend_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  bus_b ();

  function automatic logic [31:0] mem_f(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0000_5A33;
  endfunction

  assign bus_a.Stall = s_stall;
  assign bus_a.Flush = s_flush;
  assign bus_a.PCTargetE = s_tgt;
  assign bus_a.InstrF = mem_f(bus_a.PCF);
  assign bus_b.Stall = s_stall;
  assign bus_b.Flush = s_flush;
  assign bus_b.PCTargetE = s_tgt;
  assign bus_b.InstrF = mem_f(bus_b.PCF);

  pipeline_frontend #(.DATA_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(32'h13), .CNT_WIDTH(32)) dut_a (
    .clk (clk), .rst (s_rst), .bus (bus_a.slave)
  );

  pipeline_frontend #(.DATA_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(32'h13), .CNT_WIDTH(2)) dut_b (
    .clk (clk), .rst (s_rst), .bus (bus_b.slave)
  );

  function automatic logic [1:0] sat2(input longint v);
    return (v > 3) ? 2'd3 : v[1:0];
  endfunction

  // One cycle of stimulus; FlushE is sampled before the edge, model advances at the edge.
  task automatic drive(input logic st, input logic fl, input logic rs, input logic [31:0] tgt);
    @(negedge clk);
    s_stall = st; s_flush = fl; s_rst = rs; s_tgt = tgt;
    #1;
    obs_fe_a = bus_a.FlushE;
    obs_fe_b = bus_b.FlushE;
    @(posedge clk);
    if (rs) begin
      m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
    end else if (st) begin
      m_scnt++;
    end else if (fl) begin
      m_pc = tgt; m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_fcnt++;
    end else begin
      m_instr = mem_f(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset;
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    n_chk++;
    if (obs_fe_a !== 1'b1) begin n_fail++; $display("FAIL reset_flushe got %b exp 1", obs_fe_a); end
    n_chk++;
    if ({bus_a.PCF, bus_a.InstrD, bus_a.PCD, bus_a.PCPlus4D, bus_a.ValidD} !== {32'h0, 32'h13, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ifid got pc=%h instr=%h pcd=%h pc4=%h v=%b", bus_a.PCF, bus_a.InstrD, bus_a.PCD, bus_a.PCPlus4D, bus_a.ValidD);
    end
    n_chk++;
    if ({bus_a.StallCnt, bus_a.FlushCnt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus_a.StallCnt, bus_a.FlushCnt);
    end
  endtask

  task automatic test_run;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0);
      n_chk++;
      if ({bus_a.PCF, bus_a.InstrD, bus_a.ValidD, obs_fe_a} !== {32'(4 * i), mem_f(32'(4 * (i - 1))), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL run_%0d got pc=%h instr=%h v=%b fe=%b exp pc=%h instr=%h v=1 fe=0", i, bus_a.PCF, bus_a.InstrD, bus_a.ValidD, obs_fe_a, 32'(4 * i), mem_f(32'(4 * (i - 1))));
      end
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      n_chk++;
      if ({bus_a.PCF, bus_a.InstrD, obs_fe_a} !== {32'h10, mem_f(32'hC), 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold got pc=%h instr=%h fe=%b exp pc=10 instr=%h fe=1", bus_a.PCF, bus_a.InstrD, obs_fe_a, mem_f(32'hC));
      end
    end
    n_chk++;
    if (bus_a.StallCnt !== 32'd2) begin n_fail++; $display("FAIL stall_cnt got %0d exp 2", bus_a.StallCnt); end
    drive(0, 0, 0, 0);
    n_chk++;
    if ({bus_a.PCF, bus_a.InstrD} !== {32'h14, mem_f(32'h10)}) begin
      n_fail++; $display("FAIL stall_resume got pc=%h instr=%h exp pc=14", bus_a.PCF, bus_a.InstrD);
    end
  endtask

  task automatic test_flush;
    repeat (3) drive(0, 0, 0, 0);
    n_chk++;
    if (bus_a.PCF !== 32'h20) begin n_fail++; $display("FAIL flush_setup got pc=%h exp 20", bus_a.PCF); end
    drive(0, 1, 0, 32'h100);
    n_chk++;
    if ({bus_a.PCF, bus_a.InstrD, bus_a.ValidD, bus_a.PCD, bus_a.PCPlus4D, obs_fe_a} !== {32'h100, 32'h13, 1'b0, 32'h0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_redirect got pc=%h instr=%h v=%b pcd=%h pc4=%h fe=%b", bus_a.PCF, bus_a.InstrD, bus_a.ValidD, bus_a.PCD, bus_a.PCPlus4D, obs_fe_a);
    end
    drive(0, 0, 0, 0);
    n_chk++;
    if ({bus_a.InstrD, bus_a.PCD, bus_a.ValidD, bus_a.PCF, bus_a.FlushCnt} !== {mem_f(32'h100), 32'h100, 1'b1, 32'h104, 32'd1}) begin
      n_fail++;
      $display("FAIL flush_target got instr=%h pcd=%h v=%b pc=%h fcnt=%0d", bus_a.InstrD, bus_a.PCD, bus_a.ValidD, bus_a.PCF, bus_a.FlushCnt);
    end
  endtask

  task automatic test_stall_flush;
    drive(1, 1, 0, 32'h200);
    n_chk++;
    if ({bus_a.PCF, bus_a.StallCnt, bus_a.FlushCnt, obs_fe_a} !== {32'h104, 32'd3, 32'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_over_flush got pc=%h scnt=%0d fcnt=%0d fe=%b exp pc=104 scnt=3 fcnt=1 fe=1", bus_a.PCF, bus_a.StallCnt, bus_a.FlushCnt, obs_fe_a);
    end
    drive(0, 1, 0, 32'h200);
    n_chk++;
    if ({bus_a.PCF, bus_a.FlushCnt} !== {32'h200, 32'd2}) begin
      n_fail++; $display("FAIL flush_after_stall got pc=%h fcnt=%0d exp pc=200 fcnt=2", bus_a.PCF, bus_a.FlushCnt);
    end
  endtask

  task automatic test_wrap;
    drive(0, 1, 0, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0);
    n_chk++;
    if ({bus_a.PCF, bus_a.PCD, bus_a.PCPlus4D, bus_a.InstrD} !== {32'h0, 32'hFFFF_FFFC, 32'h0, mem_f(32'hFFFF_FFFC)}) begin
      n_fail++;
      $display("FAIL pc_wrap got pc=%h pcd=%h pc4=%h instr=%h", bus_a.PCF, bus_a.PCD, bus_a.PCPlus4D, bus_a.InstrD);
    end
  endtask

  task automatic test_saturate;
    drive(0, 0, 1, 0);
    repeat (3) drive(1, 0, 0, 0);
    n_chk++;
    if ({bus_b.StallCnt, bus_a.StallCnt} !== {2'd3, 32'd3}) begin
      n_fail++; $display("FAIL sat_three got small=%0d big=%0d exp 3/3", bus_b.StallCnt, bus_a.StallCnt);
    end
    drive(1, 0, 0, 0);
    n_chk++;
    if ({bus_b.StallCnt, bus_a.StallCnt} !== {2'd3, 32'd4}) begin
      n_fail++; $display("FAIL sat_four got small=%0d big=%0d exp 3/4", bus_b.StallCnt, bus_a.StallCnt);
    end
    repeat (5) drive(0, 1, 0, 32'h80);
    n_chk++;
    if ({bus_b.FlushCnt, bus_a.FlushCnt} !== {2'd3, 32'd5}) begin
      n_fail++; $display("FAIL sat_flush got small=%0d big=%0d exp 3/5", bus_b.FlushCnt, bus_a.FlushCnt);
    end
  endtask

  task automatic test_reset_mid_hold;
    drive(0, 1, 0, 32'h40);
    drive(1, 0, 0, 0);
    drive(1, 1, 1, 32'h300);
    n_chk++;
    if ({bus_a.PCF, bus_a.InstrD, bus_a.ValidD, bus_a.StallCnt, bus_a.FlushCnt, obs_fe_a} !== {32'h0, 32'h13, 1'b0, 32'd0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_hold got pc=%h instr=%h v=%b scnt=%0d fcnt=%0d fe=%b", bus_a.PCF, bus_a.InstrD, bus_a.ValidD, bus_a.StallCnt, bus_a.FlushCnt, obs_fe_a);
    end
    drive(0, 0, 1, 0);
    n_chk++;
    if (obs_fe_a !== 1'b1 || obs_fe_b !== 1'b1) begin
      n_fail++; $display("FAIL reset_flushe_idle got %b/%b exp 1/1", obs_fe_a, obs_fe_b);
    end
  endtask

  task automatic test_random;
    logic st, fl, rs;
    logic [31:0] tgt;
    int shown;
    shown = 0;
    for (int i = 0; i < 1500; i++) begin
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 99) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      drive(st, fl, rs, tgt);
      n_chk++;
      if (obs_fe_a !== (st | fl | rs) || obs_fe_b !== (st | fl | rs)) begin
        n_fail++;
        if (shown++ < 10) $display("FAIL rand_flushe cyc %0d got %b/%b exp %b", i, obs_fe_a, obs_fe_b, st | fl | rs);
      end
      n_chk++;
      if ({bus_a.PCF, bus_a.InstrD, bus_a.PCD, bus_a.PCPlus4D, bus_a.ValidD} !== {m_pc, m_instr, m_pcd, m_pc4, m_valid} ||
          {bus_b.PCF, bus_b.InstrD, bus_b.PCD, bus_b.PCPlus4D, bus_b.ValidD} !== {m_pc, m_instr, m_pcd, m_pc4, m_valid}) begin
        n_fail++;
        if (shown++ < 10) $display("FAIL rand_state cyc %0d got pc=%h instr=%h pcd=%h pc4=%h v=%b exp pc=%h instr=%h pcd=%h pc4=%h v=%b",
                                   i, bus_a.PCF, bus_a.InstrD, bus_a.PCD, bus_a.PCPlus4D, bus_a.ValidD, m_pc, m_instr, m_pcd, m_pc4, m_valid);
      end
      n_chk++;
      if ({bus_a.StallCnt, bus_a.FlushCnt, bus_b.StallCnt, bus_b.FlushCnt} !== {m_scnt[31:0], m_fcnt[31:0], sat2(m_scnt), sat2(m_fcnt)}) begin
        n_fail++;
        if (shown++ < 10) $display("FAIL rand_cnt cyc %0d got %0d/%0d small %0d/%0d exp %0d/%0d", i,
                                   bus_a.StallCnt, bus_a.FlushCnt, bus_b.StallCnt, bus_b.FlushCnt, m_scnt, m_fcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_flush();
    test_stall_flush();
    test_wrap();
    test_saturate();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_frontend.md
# pipeline_frontend

Fetch-side pipeline controller for the 5-stage RV32I core. It owns the PC register and the IF/ID pipeline register, and generates the ID/EX bubble request. It acts on the Stall and Flush decisions from the hazard unit by holding, redirecting, or squashing the front of the pipeline. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- DATA_WIDTH, 32, PC and instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)
- CNT_WIDTH, 32, event counter width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- Stall  in  1  load-use stall request from the hazard unit
- Flush  in  1  control-hazard flush; high when PCsrc in E selects a non-sequential PC
- PCTargetE  in  DATA_WIDTH  branch/jump target computed in E
- InstrF  in  DATA_WIDTH  instruction-memory read data for PCF (combinational read)
- PCF  out  DATA_WIDTH  current fetch address
- InstrD  out  DATA_WIDTH  IF/ID instruction
- PCD  out  DATA_WIDTH  IF/ID PC
- PCPlus4D  out  DATA_WIDTH  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction, not a bubble
- FlushE  out  1  clear the ID/EX register on the next edge (bubble insert)
- StallCnt  out  CNT_WIDTH  cycles with an effective stall
- FlushCnt  out  CNT_WIDTH  cycles with an effective flush

## Operation
- Action is one of RUN, HOLD or REDIRECT. It is combinational from Stall and Flush, with priority HOLD > REDIRECT > RUN:
  - HOLD when Stall=1.
  - REDIRECT when Stall=0 and Flush=1.
  - RUN otherwise.
- Stall has priority over Flush. During a load-use stall, the E-stage instruction has stale operands, so its PCsrc is not trustworthy. The Flush asserted in that cycle is ignored. The branch re-evaluates next cycle with forwarded data.
- RUN:
  - PCF <= PCF+4.
  - IF/ID <= {InstrF, PCF, PCF+4}, ValidD <= 1.
  - FlushE=0.
- HOLD:
  - PCF and IF/ID keep their values.
  - FlushE=1, so the dependent instruction moves to E next cycle behind a bubble in ID/EX.
  - StallCnt increments.
- REDIRECT:
  - PCF <= PCTargetE.
  - InstrD <= NOP_INSTR, PCD <= 0, PCPlus4D <= 0, ValidD <= 0.
  - FlushE=1.
  - FlushCnt increments.
- Counters saturate at all-ones and never wrap.
- PC arithmetic is modulo 2^DATA_WIDTH. PCF+4 wraps silently from 32'hFFFF_FFFC to 0.
- PCTargetE is loaded unmodified. Alignment is the ALU's responsibility.
- Reset values: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, StallCnt=0, FlushCnt=0.
- FlushE is forced to 1 while rst=1, so ID/EX is cleared in the same reset edge.

## Timing
- All state updates on the rising clk edge. rst is sampled on that edge and overrides Stall and Flush.
- FlushE is combinational from Stall, Flush and rst. There is no register stage.
- Fetch-to-decode latency is 1 cycle. Redirect latency: the target is in PCF 1 cycle after Flush is sampled, and its instruction is in InstrD 2 cycles after.
- Taken-branch penalty is exactly 2 bubbles: IF/ID and ID/EX.
- A stall of N consecutive cycles holds PCF for N cycles and inserts N bubbles into ID/EX.
- Back-to-back REDIRECTs are legal. Each cycle loads the newest PCTargetE.
- rst asserted mid-stall or mid-redirect takes full reset values on that edge. The pending action is discarded.

## Structure
- Shared package core_pkg holds:
  - NOP_INSTR and RESET_PC constants.
  - The typedef enum logic [1:0] {ACT_RUN, ACT_HOLD, ACT_REDIRECT} fe_action_t.
  - A packed struct if_id_t {instr, pc, pc_plus4, valid}.
- One natural sub-module, sat_counter: parameterised width, synchronous reset, enable input, saturating increment. It is instantiated twice.
- The rest is a single always_ff for PC and IF/ID plus an always_comb action decoder.

## Test plan
- Reset release, RESET_PC=0, Stall=Flush=0, InstrF driven as mem[PC]:
  - PCF goes 0,4,8,12 on successive cycles.
  - InstrD lags one cycle; ValidD=1 from the second cycle.
  - FlushE=0.
- Stall high for 2 cycles at PCF=0x10:
  - PCF stays 0x10 for 2 cycles and InstrD is unchanged.
  - FlushE=1 both cycles; StallCnt=2.
  - Then PCF=0x14.
- Flush with PCTargetE=0x100 at PCF=0x20:
  - Next cycle PCF=0x100, InstrD=0x13, ValidD=0, FlushE=1 in the Flush cycle.
  - Next-but-one cycle InstrD=mem[0x100]; FlushCnt=1.
- Stall=1 and Flush=1 together, PCTargetE=0x200:
  - PCF held and HOLD behaviour applies.
  - FlushCnt unchanged, StallCnt+1.
  - Next cycle Flush=1 alone redirects to 0x200.
- Wrap and saturate:
  - PCF=32'hFFFF_FFFC with RUN gives PCF=0.
  - With CNT_WIDTH=2, four stalls leave StallCnt=3.
- rst asserted during HOLD at PCF=0x40:
  - Next cycle PCF=RESET_PC, InstrD=0x13, ValidD=0, both counters 0, FlushE=1 during reset.
